// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Includes a population-count helper used for the outstanding-write counter.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 16;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = {REG_AW{1'b0}};

  function automatic logic [REG_AW:0] popcount(input logic [NUM_REGS-1:0] vec);
    logic [REG_AW:0] cnt;
    cnt = {(REG_AW+1){1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt = cnt + {{REG_AW{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_arb.sv
// Two-requester round-robin arbiter; after any grant the other requester is preferred.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_r = 0 prefers req[0], 1 prefers req[1]
  logic ptr_r;

  // Grant selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_r ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (gnt[0]) begin
      ptr_r <= 1'b1;
    end else if (gnt[1]) begin
      ptr_r <= 1'b0;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write scheduler: pending-write scoreboard, RAW/WAW issue stall and
// round-robin sharing of the single write port between ALU (wb0) and load (wb1) results.
module regfile_wb_scheduler
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  reg_idx_t          issue_rs1,
  input  reg_idx_t          issue_rs2,
  input  reg_idx_t          issue_rd,
  input  logic              issue_wr,
  input  logic              wb0_valid,
  output logic              wb0_ready,
  input  reg_idx_t          wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  reg_idx_t          wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output reg_idx_t          rf_dest,
  output logic [DATA_W-1:0] rf_din,
  output logic [REG_AW:0]   outstanding,
  output logic              wb_err
);

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [1:0]          gnt_s;
  logic                issue_fire_s;
  logic                wb_xfer_s;
  reg_idx_t            wb_rd_s;
  logic [DATA_W-1:0]   wb_data_s;
  logic                wb_orphan_s;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({wb1_valid, wb0_valid}),
    .gnt (gnt_s)
  );

  assign wb0_ready = gnt_s[0];
  assign wb1_ready = gnt_s[1];
  assign wb_xfer_s = gnt_s[0] | gnt_s[1];

  // Hazard check sees only registered pend: a writeback completing this cycle does not unblock issue
  assign issue_ready  = ~(pend_r[issue_rs1] | pend_r[issue_rs2] | (issue_wr & pend_r[issue_rd]));
  assign issue_fire_s = issue_valid & issue_ready;

  // Granted writeback source mux
  always_comb begin
    if (gnt_s[1]) begin
      wb_rd_s   = wb1_rd;
      wb_data_s = wb1_data;
    end else begin
      wb_rd_s   = wb0_rd;
      wb_data_s = wb0_data;
    end
  end

  assign wb_orphan_s = wb_xfer_s & (wb_rd_s != REG_ZERO) & ~pend_r[wb_rd_s];

  // Scoreboard next state; set is applied after clear so it wins on a collision
  always_comb begin
    pend_nxt_s = pend_r;
    if (wb_xfer_s) begin
      pend_nxt_s[wb_rd_s] = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (issue_fire_s && issue_wr) begin
      pend_nxt_s[issue_rd] = 1'b1;
    end else begin
      pend_nxt_s[0] = 1'b0;
    end
    pend_nxt_s[0] = 1'b0;
  end

  // Scoreboard, counter and register-file write port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r      <= {NUM_REGS{1'b0}};
      outstanding <= {(REG_AW+1){1'b0}};
      rf_dest     <= REG_ZERO;
      rf_din      <= {DATA_W{1'b0}};
      wb_err      <= 1'b0;
    end else begin
      pend_r      <= pend_nxt_s;
      outstanding <= popcount(pend_nxt_s);
      rf_dest     <= wb_xfer_s ? wb_rd_s : REG_ZERO;
      rf_din      <= wb_xfer_s ? wb_data_s : rf_din;
      wb_err      <= wb_err | wb_orphan_s;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench: directed vector table, corner sequences and random traffic
// compared against a behavioural scoreboard/arbitration model.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready, issue_wr;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [3:0]  wb0_rd, wb1_rd;
  logic [31:0] wb0_data, wb1_data;
  logic [3:0]  rf_dest;
  logic [31:0] rf_din;
  logic [4:0]  outstanding;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_wr(issue_wr),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_rd(wb0_rd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_rd(wb1_rd), .wb1_data(wb1_data),
    .rf_dest(rf_dest), .rf_din(rf_din), .outstanding(outstanding), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst, iv, wr;
    logic [3:0]  rs1, rs2, rd;
    bit          v0; logic [3:0] rd0; logic [31:0] d0;
    bit          v1; logic [3:0] rd1; logic [31:0] d1;
    bit          e_rdy, e_g0, e_g1;
    logic [3:0]  e_dest; logic [31:0] e_din; logic [4:0] e_out; bit e_err;
  } vec_t;

  // Reference model state
  bit          m_pend [16];
  int          m_ptr;
  logic [3:0]  m_dest;
  logic [31:0] m_din;
  bit          m_err;

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_pend[i] ? 1 : 0;
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; issue_valid = v.iv; issue_wr = v.wr;
    issue_rs1 = v.rs1; issue_rs2 = v.rs2; issue_rd = v.rd;
    wb0_valid = v.v0; wb0_rd = v.rd0; wb0_data = v.d0;
    wb1_valid = v.v1; wb1_rd = v.rd1; wb1_data = v.d1;
  endtask

  task automatic step(input vec_t v, input bit use_tab);
    int          win;
    bit          rdy;
    logic [3:0]  wrd;
    logic [31:0] wd;
    drive(v);
    #1;
    rdy = !(m_pend[v.rs1] || m_pend[v.rs2] || (v.wr && m_pend[v.rd]));
    if (v.v0 && v.v1)  win = m_ptr;
    else if (v.v0)     win = 0;
    else if (v.v1)     win = 1;
    else               win = -1;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
    chk("wb0_ready", {31'd0, wb0_ready}, {31'd0, win == 0});
    chk("wb1_ready", {31'd0, wb1_ready}, {31'd0, win == 1});
    if (use_tab) begin
      chk("tab_issue_ready", {31'd0, issue_ready}, {31'd0, v.e_rdy});
      chk("tab_wb0_ready", {31'd0, wb0_ready}, {31'd0, v.e_g0});
      chk("tab_wb1_ready", {31'd0, wb1_ready}, {31'd0, v.e_g1});
    end
    @(posedge clk);
    cyc++;
    if (v.rst) begin
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ptr = 0; m_dest = 4'd0; m_din = 32'd0; m_err = 1'b0;
    end else begin
      if (win >= 0) begin
        wrd = (win == 0) ? v.rd0 : v.rd1;
        wd  = (win == 0) ? v.d0  : v.d1;
        if (wrd != 4'd0 && !m_pend[wrd]) m_err = 1'b1;
        m_pend[wrd] = 1'b0;
        m_dest = wrd;
        m_din  = wd;
        m_ptr  = 1 - win;
      end else begin
        m_dest = 4'd0;
      end
      if (v.iv && rdy && v.wr && v.rd != 4'd0) m_pend[v.rd] = 1'b1;
    end
    #1;
    chk("rf_dest", {28'd0, rf_dest}, {28'd0, m_dest});
    chk("rf_din", rf_din, m_din);
    chk("outstanding", {27'd0, outstanding}, m_count());
    chk("wb_err", {31'd0, wb_err}, {31'd0, m_err});
    if (use_tab) begin
      chk("tab_rf_dest", {28'd0, rf_dest}, {28'd0, v.e_dest});
      chk("tab_rf_din", rf_din, v.e_din);
      chk("tab_outstanding", {27'd0, outstanding}, {27'd0, v.e_out});
      chk("tab_wb_err", {31'd0, wb_err}, {31'd0, v.e_err});
    end
  endtask

  vec_t tab [14];
  vec_t v;

  initial begin
    // rst iv wr rs1 rs2 rd | v0 rd0 d0 | v1 rd1 d1 | rdy g0 g1 | dest din out err
    tab[0]  = '{0,1,1,0,0,3, 0,0,32'h0,         0,0,32'h0,         1,0,0, 0,32'h0,1,0};
    tab[1]  = '{0,1,0,3,0,0, 0,0,32'h0,         0,0,32'h0,         0,0,0, 0,32'h0,1,0};
    tab[2]  = '{0,1,0,3,0,0, 1,3,32'hDEADBEEF,  0,0,32'h0,         0,1,0, 3,32'hDEADBEEF,0,0};
    tab[3]  = '{0,1,0,3,0,0, 0,0,32'h0,         0,0,32'h0,         1,0,0, 0,32'hDEADBEEF,0,0};
    tab[4]  = '{0,1,1,0,0,1, 0,0,32'h0,         0,0,32'h0,         1,0,0, 0,32'hDEADBEEF,1,0};
    tab[5]  = '{0,1,1,0,0,2, 0,0,32'h0,         0,0,32'h0,         1,0,0, 0,32'hDEADBEEF,2,0};
    tab[6]  = '{0,1,1,0,0,0, 1,0,32'h11111111,  0,0,32'h0,         1,1,0, 0,32'h11111111,2,0};
    tab[7]  = '{0,0,0,0,0,0, 0,0,32'h0,         1,0,32'h22222222,  1,0,1, 0,32'h22222222,2,0};
    tab[8]  = '{0,0,0,0,0,0, 1,1,32'hA1A1A1A1,  1,2,32'hB2B2B2B2,  1,1,0, 1,32'hA1A1A1A1,1,0};
    tab[9]  = '{0,1,1,0,0,1, 1,1,32'hA1A1A1A1,  1,2,32'hB2B2B2B2,  1,0,1, 2,32'hB2B2B2B2,1,0};
    tab[10] = '{0,1,1,0,0,2, 1,1,32'hC3C3C3C3,  1,2,32'hD4D4D4D4,  1,1,0, 1,32'hC3C3C3C3,1,0};
    tab[11] = '{0,0,0,0,0,0, 1,1,32'hC3C3C3C3,  1,2,32'hE5E5E5E5,  1,0,1, 2,32'hE5E5E5E5,0,0};
    tab[12] = '{0,0,0,0,0,0, 0,0,32'h0,         1,5,32'h5555AAAA,  1,0,1, 5,32'h5555AAAA,0,1};
    tab[13] = '{0,0,0,0,0,0, 0,0,32'h0,         0,0,32'h0,         1,0,0, 0,32'h5555AAAA,0,1};

    v = '{1,0,0,0,0,0, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,32'h0,0,0};
    drive(v);
    repeat (2) @(posedge clk);
    #1;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    m_ptr = 0; m_dest = 4'd0; m_din = 32'd0; m_err = 1'b0;
    chk("reset_rf_dest", {28'd0, rf_dest}, 32'd0);
    chk("reset_rf_din", rf_din, 32'd0);
    chk("reset_outstanding", {27'd0, outstanding}, 32'd0);
    chk("reset_wb_err", {31'd0, wb_err}, 32'd0);
    chk("reset_issue_ready", {31'd0, issue_ready}, 32'd1);

    for (int i = 0; i < 14; i++) step(tab[i], 1'b1);

    // Fill every architectural register with a pending write
    for (int r = 1; r < 16; r++) begin
      v = '{0,1,1,0,0,r[3:0], 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,32'h5555AAAA,r[4:0],1};
      step(v, 1'b1);
    end
    v = '{0,1,1,0,0,7, 0,0,32'h0, 0,0,32'h0, 0,0,0, 0,32'h5555AAAA,15,1};
    step(v, 1'b1);
    v = '{0,1,0,0,0,7, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,32'h5555AAAA,15,1};
    step(v, 1'b1);
    v = '{0,1,0,5,0,0, 0,0,32'h0, 0,0,32'h0, 0,0,0, 0,32'h5555AAAA,15,1};
    step(v, 1'b1);
    // Reset while a writeback is being granted
    v = '{1,1,1,0,0,0, 1,3,32'h12345678, 0,0,32'h0, 1,1,0, 0,32'h0,0,0};
    step(v, 1'b1);
    v = '{0,1,1,5,6,7, 0,0,32'h0, 0,0,32'h0, 1,0,0, 0,32'h0,1,0};
    step(v, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      v.rst = ($urandom_range(0, 99) == 0);
      v.iv  = $urandom_range(0, 1);
      v.wr  = ($urandom_range(0, 3) != 0);
      v.rs1 = $urandom_range(0, 15);
      v.rs2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      v.rd  = $urandom_range(0, 15);
      v.v0  = ($urandom_range(0, 2) == 0);
      v.rd0 = $urandom_range(0, 15);
      v.d0  = $urandom;
      v.v1  = ($urandom_range(0, 2) == 0);
      v.rd1 = $urandom_range(0, 15);
      v.d1  = $urandom;
      step(v, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
